// File: rtl/mm_result_collector.sv
// mm_result_collector
// Reassembles per-lane results from the multiply array into N-lane vectors
// and queues them in a DEPTH-entry FIFO that drains on a valid/ready stream.
// Optional build macro: MM_COLLECT_ERR_EN enables duplicate and overflow
// detection on err[1:0]; without it err is tied to zero.
//
// Handshake: a vector leaves the FIFO on every cycle where out_valid and
// out_ready are both high; out_data is stable while out_valid && !out_ready.
module mm_result_collector #(
  parameter int N     = 16,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW*N-1:0]          vector_output,
  input  logic [N-1:0]             add_valid,
  output logic [DW*N-1:0]          out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     stall,
  output logic [1:0]               err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Assembly state is implied by the capture mask: all ones means FULL.
  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_FULL    = 1'b1;

  logic [DW*N-1:0] asm_data_q, asm_data_d;
  logic [N-1:0]    asm_mask_q, asm_mask_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [DW*N-1:0] mem_q [DEPTH];
  logic [0:0]      state;
  logic            push;
  logic            pop;
`ifdef MM_COLLECT_ERR_EN
  logic [1:0]      err_q, err_d;
  logic            dup_seen;
  logic            ovf_seen;
`endif

  assign state      = (&asm_mask_q) ? ST_FULL : ST_COLLECT;
  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign stall      = (count_q == FULL_CNT);

  // FIFO push/pop decisions; a full FIFO still has room when it pops this cycle.
  always_comb begin
    pop  = out_valid && out_ready;
    push = (state == ST_FULL) && ((count_q != FULL_CNT) || pop);
  end

  // Lane capture into the assembly register and error detection.
  always_comb begin
    asm_data_d = asm_data_q;
    asm_mask_d = asm_mask_q;
`ifdef MM_COLLECT_ERR_EN
    dup_seen   = 1'b0;
    ovf_seen   = 1'b0;
`endif
    case (state)
      ST_COLLECT: begin
        for (int i = 0; i < N; i++) begin
          if (add_valid[i]) begin
`ifdef MM_COLLECT_ERR_EN
            // First value wins; a repeat strobe only flags the error.
            if (asm_mask_q[i]) begin
              dup_seen = 1'b1;
            end else begin
              asm_data_d[i*DW +: DW] = vector_output[i*DW +: DW];
              asm_mask_d[i]          = 1'b1;
            end
`else
            // Last value wins on a repeat strobe.
            asm_data_d[i*DW +: DW] = vector_output[i*DW +: DW];
            asm_mask_d[i]          = 1'b1;
`endif
          end
        end
      end
      default: begin
        if (push) begin
          // Strobes arriving with the push start the next vector.
          asm_mask_d = add_valid;
          for (int i = 0; i < N; i++) begin
            if (add_valid[i]) asm_data_d[i*DW +: DW] = vector_output[i*DW +: DW];
          end
        end else begin
          // No room: hold the vector, in-flight strobes are dropped.
`ifdef MM_COLLECT_ERR_EN
          ovf_seen = |add_valid;
`endif
        end
      end
    endcase
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

`ifdef MM_COLLECT_ERR_EN
  // Sticky error flags, cleared only by reset.
  always_comb begin
    err_d = err_q | {ovf_seen, dup_seen};
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 2'b00;
`endif

  // Assembly and FIFO control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_data_q <= '0;
      asm_mask_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      asm_data_q <= asm_data_d;
      asm_mask_q <= asm_mask_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= asm_data_q;
  end

endmodule

// File: doc/mm_result_collector.md
# mm_result_collector

Receive-side companion of the matrix-vector multiply array: captures the per-lane results that each column pipeline emits with its own `add_valid` pulse, reassembles them into complete N-lane result vectors, and queues them in a small FIFO. The drained vectors go out on a valid/ready stream toward the writeback path. A `stall` signal tells the issuing side to stop asserting `input_valid` while the queue is full.

## Interface
- `N`, 16, number of lanes (columns) per result vector
- `DW`, 32, lane data width in bits
- `DEPTH`, 4, FIFO depth in vectors; power of two, ≥ 2
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `vector_output`  in  DW*N  lane results from the multiply array; lane i at bits [(i+1)*DW-1 : i*DW]
- `add_valid`  in  N  per-lane result strobe; bit i qualifies lane i for one cycle
- `out_data`  out  DW*N  head-of-FIFO result vector, same lane packing as the input
- `out_valid`  out  1  `out_data` holds a complete vector
- `out_ready`  in  1  downstream accepts the vector this cycle
- `fifo_count`  out  $clog2(DEPTH)+1  number of vectors queued
- `stall`  out  1  FIFO full; issuer must hold off new multiplies
- `err`  out  2  sticky flags: [0] duplicate lane strobe, [1] overflow drop

## Operation
- Assembly register `asm_data` (DW*N) with capture mask `asm_mask` (N).
- State COLLECT (`asm_mask` not all ones):
  - For every lane i with `add_valid[i]`=1 and `asm_mask[i]`=0: capture lane i into `asm_data` and set `asm_mask[i]`.
  - A lane with `add_valid[i]`=1 and `asm_mask[i]`=1 is a duplicate. Its data is not captured and `err[0]` is set.
- State FULL (`asm_mask` all ones):
  - Push `asm_data` into the FIFO if there is space. Space exists when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - On a push: `asm_mask` is loaded with `add_valid` and those lanes are captured. These lanes start the next vector. The block returns to COLLECT, or stays in FULL if N bits were set.
  - With no space: hold `asm_data`. Any `add_valid` bit seen in this cycle is dropped and sets `err[1]`.
- FIFO behaviour:
  - Pop when `out_valid` && `out_ready`.
  - Simultaneous push and pop leaves `fifo_count` unchanged.
  - Read and write pointers wrap modulo DEPTH.
- `out_data` = FIFO head. It holds stable while `out_valid` && !`out_ready`.
- `stall` = (`fifo_count` == DEPTH).
- `err` bits stay set until `rst`.
- Lane arithmetic is pure data movement; no width change.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `fifo_count`=0, `stall`=0, `err`=0. Internal state: `asm_mask`=0, pointers at 0, state COLLECT.
- `rst` asserted mid-operation discards any partial vector and all queued vectors on the next edge.
- Latency: last missing lane strobed in cycle t → state FULL in t+1 → push at the end of t+1 (FIFO not full) → `out_valid`=1 in cycle t+2.
- Lanes may arrive in any order and across any number of cycles. Simultaneous strobes on all N lanes are legal.
- Back-to-back vectors need no bubble: all N strobes in every cycle yields one push per cycle once the pipeline is primed.
- `stall` is registered from `fifo_count`. The issuer must tolerate results already in flight in the array; those are the overflow case.

## Configuration
- `MM_COLLECT_ERR_EN` defined:
  - Duplicate and overflow detection are implemented as described.
  - Duplicates are ignored (first value wins).
- `MM_COLLECT_ERR_EN` undefined:
  - `err` is tied to 0 and no detection logic is built.
  - A duplicate strobe overwrites the lane (last value wins).
  - Overflow strobes are silently dropped.

## Test plan
- Reset, then all 16 `add_valid` bits high in one cycle with lane i = i+1, `out_ready`=1 → `out_valid` two cycles later, `out_data` lane i = i+1, `fifo_count` returns to 0.
- Lanes strobed one per cycle in reverse order 15..0 → exactly one vector is pushed, with correct lane placement, `out_valid` 2 cycles after the lane-0 strobe.
- `out_ready`=0 and 5 complete vectors, DEPTH=4 → `stall`=1 after the 4th push, 5th vector held in FULL. Extra strobe in that state sets `err[1]`=1. Then `out_ready`=1 → vectors 1..4 drain in order, followed by the 5th.
- Lane 3 strobed twice (0xAAAA then 0xBBBB) before completion → with `MM_COLLECT_ERR_EN`: lane 3 = 0xAAAA and `err[0]`=1. Without: lane 3 = 0xBBBB and `err`=0.
- FIFO full with a push and pop in the same cycle → `fifo_count` stays 4, no drop, no `err[1]`.
- `rst` pulsed with 9 lanes captured and 2 vectors queued → next cycle `out_valid`=0 and `fifo_count`=0. A fresh full vector then emerges alone.
